// File: rtl/shared_out_arbiter.sv
// shared_out_arbiter: round-robin owner of one W-bit output bundle.
// Grants a burst to one requester at a time; ends the burst on a 'last'
// beat, when the owner drops its request, or when the owner has gone
// TIMEOUT consecutive cycles without a beat. O is always registered, so
// while nobody is presenting a beat it carries DEFAULT rather than being undriven.
module shared_out_arbiter #(
  parameter int unsigned    N       = 4,
  parameter int unsigned    W       = 5,
  parameter logic [W-1:0]   DEFAULT = '0,
  parameter int unsigned    TIMEOUT = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         valid,
  input  logic [N*W-1:0]       data,
  input  logic [N-1:0]         last,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] owner,
  output logic [W-1:0]         O,
  output logic                 O_valid,
  output logic                 timeout
);

  localparam int unsigned     OW         = $clog2(N);
  localparam int unsigned     WW         = $clog2(TIMEOUT);
  localparam logic [WW-1:0]   WDOG_LIMIT = WW'(TIMEOUT - 1);

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } state_t;

  state_t          state;
  logic [OW-1:0]   rr_ptr;
  logic [WW-1:0]   wdog;

  logic [OW-1:0]   cand;
  logic [OW-1:0]   win_idx;
  logic [N-1:0]    win_onehot;
  logic            found;

  logic            own_req;
  logic            own_valid;
  logic            own_last;
  logic [W-1:0]    own_data;
  logic [OW-1:0]   next_ptr;
  logic            wdog_expired;
  logic            release_now;

  // Round-robin pick: first requester at or after rr_ptr, wrapping modulo N.
  always_comb begin
    cand       = '0;
    win_idx    = '0;
    win_onehot = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = OW'((32'(rr_ptr) + i) % N);
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
    win_onehot[win_idx] = 1'b1;
  end

  // Pull out the current owner's request, beat and slice; everyone else is ignored.
  always_comb begin
    own_req   = 1'b0;
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = DEFAULT;
    for (int unsigned i = 0; i < N; i++) begin
      if (owner == OW'(i)) begin
        own_req   = req[i];
        own_valid = valid[i];
        own_last  = last[i];
        own_data  = data[i*W +: W];
      end
    end
    next_ptr     = (32'(owner) == N - 1) ? '0 : owner + 1'b1;
    wdog_expired = !own_valid && (wdog == WDOG_LIMIT);
    release_now  = (own_valid && own_last) || !own_req || wdog_expired;
  end

  // Arbitration FSM with registered grant/owner/output/timeout.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= ST_IDLE;
      grant   <= '0;
      owner   <= '0;
      rr_ptr  <= '0;
      O       <= DEFAULT;
      O_valid <= 1'b0;
      timeout <= 1'b0;
      wdog    <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          O       <= DEFAULT;
          O_valid <= 1'b0;
          if (|req) begin
            state <= ST_BURST;
            grant <= win_onehot;
            owner <= win_idx;
            wdog  <= '0;
          end
        end
        ST_BURST: begin
          if (own_valid) begin
            O       <= own_data;
            O_valid <= 1'b1;
            wdog    <= '0;
          end else begin
            O       <= DEFAULT;
            O_valid <= 1'b0;
            wdog    <= wdog + 1'b1;
          end
          // Beat is still registered above in the release cycle; a dropped
          // request outranks the watchdog, so no pulse in that case.
          if (release_now) begin
            state   <= ST_IDLE;
            grant   <= '0;
            rr_ptr  <= next_ptr;
            wdog    <= '0;
            timeout <= own_req && wdog_expired;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
